board_memory: RTL and testbench

- Parametrised, clocked successor to the tic-tac-toe input memory for a BOARD_DIM x BOARD_DIM board.
- Captures one-cell-per-press moves from debounced cell buttons and rejects occupied cells, multi-press and post-game presses.
- Alternates player ownership and keeps per-player occupancy vectors.
- Sits between the button/debounce front end and the win-detect logic; win-detect drives `dis` back to freeze the board.

---
 rtl/ttt_pkg.sv | 32 +++
 rtl/press_edge.sv | 38 +++
 rtl/board_memory.sv | 127 ++++++++++++
 tb/tb_board_memory.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and helpers for the tic-tac-toe board memory.
//   player_t   : owner / player-to-move encoding (A = 0, B = 1)
//   ncell()    : cell count for a square board of side dim
//   onehot_chk : classifies a vector as {is_zero, is_onehot}
package ttt_pkg;

  typedef enum logic {
    PLAYER_A = 1'b0,
    PLAYER_B = 1'b1
  } player_t;

  // Widest board supported (8x8); vectors are zero-extended to this width.
  localparam int unsigned MAX_NCELL = 64;

  typedef struct packed {
    logic is_zero;
    logic is_onehot;
  } onehot_t;

  function automatic int unsigned ncell(input int unsigned dim);
    return dim * dim;
  endfunction

  // A vector is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
  function automatic onehot_t onehot_chk(input logic [MAX_NCELL-1:0] vec);
    onehot_t r;
    r.is_zero   = (vec == '0);
    r.is_onehot = !r.is_zero && ((vec & (vec - MAX_NCELL'(1))) == '0);
    return r;
  endfunction

endpackage

// File: rtl/press_edge.sv
// Rising-edge detector for the debounced cell buttons.
//   clk         : system clock
//   res         : async active-low reset, presets the history to all ones
//   press       : level button inputs, one bit per cell
//   rise        : cells whose button went high this cycle (combinational)
//   rise_none   : no rising edge this cycle
//   rise_onehot : exactly one rising edge this cycle
module press_edge
  import ttt_pkg::*;
#(
  parameter int unsigned NCELL = 9
) (
  input  logic             clk,
  input  logic             res,
  input  logic [NCELL-1:0] press,
  output logic [NCELL-1:0] rise,
  output logic             rise_none,
  output logic             rise_onehot
);

  logic [NCELL-1:0] press_q;
  onehot_t          oh;

  // History presets to ones so a button held through reset never looks like a new press.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      press_q <= '1;
    end else begin
      press_q <= press;
    end
  end

  assign rise        = press & ~press_q;
  assign oh          = onehot_chk(MAX_NCELL'(rise));
  assign rise_none   = oh.is_zero;
  assign rise_onehot = oh.is_onehot;

endmodule

// File: rtl/board_memory.sv
// Move memory for a BOARD_DIM x BOARD_DIM tic-tac-toe board.
// Accepts one new cell per rising button edge, alternates ownership between
// players A and B, and rejects multi-presses, occupied cells, presses while
// frozen (dis) and presses on a full board.
//   clk      : system clock
//   res      : async active-low reset
//   press    : debounced cell buttons, bit i = cell i (row-major)
//   clr      : synchronous new-game request
//   dis      : game-over freeze from win detect
//   A, B     : per-player occupancy
//   state    : player to move next (0 = A, 1 = B)
//   move_cnt : accepted moves this game
//   full     : every cell taken (combinational from move_cnt)
//   move_ok  : one-cycle pulse, move accepted
//   move_rej : one-cycle pulse, press edge rejected
module board_memory
  import ttt_pkg::*;
#(
  parameter int unsigned BOARD_DIM    = 3,
  parameter bit          FIRST_PLAYER = 1'b0,
  parameter bit          ALT_START    = 1'b0,
  parameter int unsigned CNT_W        = $clog2(BOARD_DIM * BOARD_DIM + 1)
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic [BOARD_DIM*BOARD_DIM-1:0] press,
  input  logic                           clr,
  input  logic                           dis,
  output logic [BOARD_DIM*BOARD_DIM-1:0] A,
  output logic [BOARD_DIM*BOARD_DIM-1:0] B,
  output logic                           state,
  output logic [CNT_W-1:0]               move_cnt,
  output logic                           full,
  output logic                           move_ok,
  output logic                           move_rej
);

  localparam int unsigned NCELL = ncell(BOARD_DIM);

  logic [NCELL-1:0] rise;
  logic             rise_none;
  logic             rise_onehot;
  logic [NCELL-1:0] taken;

  logic [NCELL-1:0] a_q, a_d;
  logic [NCELL-1:0] b_q, b_d;
  player_t          turn_q, turn_d;
  player_t          start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ok_q, ok_d;
  logic             rej_q, rej_d;

  press_edge #(
    .NCELL(NCELL)
  ) u_press_edge (
    .clk        (clk),
    .res        (res),
    .press      (press),
    .rise       (rise),
    .rise_none  (rise_none),
    .rise_onehot(rise_onehot)
  );

  assign taken = rise & (a_q | b_q);
  assign full  = (cnt_q == CNT_W'(NCELL));

  // Board state registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      a_q     <= '0;
      b_q     <= '0;
      turn_q  <= player_t'(FIRST_PLAYER);
      start_q <= player_t'(FIRST_PLAYER);
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      turn_q  <= turn_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      rej_q   <= rej_d;
    end
  end

  // Next state: clr beats reject, reject beats accept.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    turn_d  = turn_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    rej_d   = 1'b0;
    if (clr) begin
      // Any press edge in the clr cycle is dropped silently.
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      start_d = ALT_START ? player_t'(~start_q) : player_t'(FIRST_PLAYER);
      turn_d  = start_d;
    end else if (!rise_none) begin
      if (!rise_onehot || (taken != '0) || dis || full) begin
        rej_d = 1'b1;
      end else begin
        if (turn_q == PLAYER_A) begin
          a_d = a_q | rise;
        end else begin
          b_d = b_q | rise;
        end
        turn_d = (turn_q == PLAYER_A) ? PLAYER_B : PLAYER_A;
        cnt_d  = cnt_q + CNT_W'(1);
        ok_d   = 1'b1;
      end
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign state    = turn_q;
  assign move_cnt = cnt_q;
  assign move_ok  = ok_q;
  assign move_rej = rej_q;

endmodule

// File: tb/tb_board_memory.sv
// Bench for board_memory: a 3x3 instance (fixed start) and a 4x4 instance
// (alternating start), table vectors, hand sequences, and a random stream
// against a cell-ownership model.
module tb_board_memory;

  logic        clk = 1'b0;
  logic        res;

  logic [8:0]  p3;
  logic        clr3, dis3;
  logic [8:0]  a3, b3;
  logic        st3, full3, ok3, rej3;
  logic [3:0]  cnt3;

  logic [15:0] p4;
  logic        clr4, dis4;
  logic [15:0] a4, b4;
  logic        st4, full4, ok4, rej4;
  logic [4:0]  cnt4;

  int n_chk  = 0;
  int n_pass = 0;
  logic inv_en = 1'b0;

  always #5 clk = ~clk;

  board_memory #(.BOARD_DIM(3), .FIRST_PLAYER(1'b0), .ALT_START(1'b0)) u_dut3 (
    .clk(clk), .res(res), .press(p3), .clr(clr3), .dis(dis3),
    .A(a3), .B(b3), .state(st3), .move_cnt(cnt3), .full(full3),
    .move_ok(ok3), .move_rej(rej3)
  );

  board_memory #(.BOARD_DIM(4), .FIRST_PLAYER(1'b0), .ALT_START(1'b1)) u_dut4 (
    .clk(clk), .res(res), .press(p4), .clr(clr4), .dis(dis4),
    .A(a4), .B(b4), .state(st4), .move_cnt(cnt4), .full(full4),
    .move_ok(ok4), .move_rej(rej4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic check3(input string nm, input logic [8:0] ea, input logic [8:0] eb,
                        input logic est, input logic [3:0] ec, input logic eok,
                        input logic erej);
    chk({nm, "_A"},    32'(a3),    32'(ea));
    chk({nm, "_B"},    32'(b3),    32'(eb));
    chk({nm, "_st"},   32'(st3),   32'(est));
    chk({nm, "_cnt"},  32'(cnt3),  32'(ec));
    chk({nm, "_full"}, 32'(full3), 32'(ec == 4'd9));
    chk({nm, "_ok"},   32'(ok3),   32'(eok));
    chk({nm, "_rej"},  32'(rej3),  32'(erej));
  endtask

  task automatic check4(input string nm, input logic [15:0] ea, input logic [15:0] eb,
                        input logic est, input logic [4:0] ec, input logic eok,
                        input logic erej);
    chk({nm, "_A"},    32'(a4),    32'(ea));
    chk({nm, "_B"},    32'(b4),    32'(eb));
    chk({nm, "_st"},   32'(st4),   32'(est));
    chk({nm, "_cnt"},  32'(cnt4),  32'(ec));
    chk({nm, "_full"}, 32'(full4), 32'(ec == 5'd16));
    chk({nm, "_ok"},   32'(ok4),   32'(eok));
    chk({nm, "_rej"},  32'(rej4),  32'(erej));
  endtask

  task automatic step3(input logic [8:0] p, input logic c, input logic d);
    p3 = p; clr3 = c; dis3 = d;
    @(posedge clk); #1;
  endtask

  task automatic step4(input logic [15:0] p, input logic c);
    p4 = p; clr4 = c; dis4 = 1'b0;
    @(posedge clk); #1;
  endtask

  // Structural invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      int d3, d4;
      d3 = $countones(a3) - $countones(b3);
      d4 = $countones(a4) - $countones(b4);
      chk("inv3_disjoint", 32'(a3 & b3), 32'd0);
      chk("inv3_sum", 32'($countones(a3) + $countones(b3)), 32'(cnt3));
      chk("inv3_bal", 32'(d3 >= -1 && d3 <= 1), 32'd1);
      chk("inv3_pulse", 32'(ok3 & rej3), 32'd0);
      chk("inv4_disjoint", 32'(a4 & b4), 32'd0);
      chk("inv4_sum", 32'($countones(a4) + $countones(b4)), 32'(cnt4));
      chk("inv4_bal", 32'(d4 >= -1 && d4 <= 1), 32'd1);
      chk("inv4_pulse", 32'(ok4 & rej4), 32'd0);
    end
  end

  typedef struct {
    logic [8:0] p;
    logic       c;
    logic       d;
    logic [8:0] ea;
    logic [8:0] eb;
    logic       est;
    logic [3:0] ecnt;
    logic       eok;
    logic       erej;
  } vec_t;

  vec_t tbl[22];

  // Reference model for the 3x3 instance: owner per cell (0 none, 1 A, 2 B).
  int         owner[9];
  int         turn;
  int         moves;
  logic [8:0] prev;

  function automatic logic [8:0] own_vec(input int who);
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) if (owner[i] == who) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) owner[i] = 0;
    moves = 0;
    turn  = 0;
  endtask

  initial begin
    tbl[0]  = '{9'h000, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{9'h001, 1'b0, 1'b0, 9'h001, 9'h000, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{9'h003, 1'b0, 1'b0, 9'h001, 9'h002, 1'b0, 4'd2, 1'b1, 1'b0};
    tbl[3]  = '{9'h013, 1'b0, 1'b0, 9'h011, 9'h002, 1'b1, 4'd3, 1'b1, 1'b0};
    tbl[4]  = '{9'h01B, 1'b0, 1'b0, 9'h011, 9'h00A, 1'b0, 4'd4, 1'b1, 1'b0};
    tbl[5]  = '{9'h05B, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b1, 1'b0};
    tbl[6]  = '{9'h000, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[7]  = '{9'h010, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b1};
    tbl[8]  = '{9'h000, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[9]  = '{9'h024, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b1};
    tbl[10] = '{9'h000, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[11] = '{9'h004, 1'b0, 1'b1, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b1};
    tbl[12] = '{9'h004, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[13] = '{9'h000, 1'b0, 1'b0, 9'h051, 9'h00A, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[14] = '{9'h004, 1'b0, 1'b0, 9'h051, 9'h00E, 1'b0, 4'd6, 1'b1, 1'b0};
    tbl[15] = '{9'h020, 1'b0, 1'b0, 9'h071, 9'h00E, 1'b1, 4'd7, 1'b1, 1'b0};
    tbl[16] = '{9'h080, 1'b0, 1'b0, 9'h071, 9'h08E, 1'b0, 4'd8, 1'b1, 1'b0};
    tbl[17] = '{9'h100, 1'b0, 1'b0, 9'h171, 9'h08E, 1'b1, 4'd9, 1'b1, 1'b0};
    tbl[18] = '{9'h000, 1'b0, 1'b0, 9'h171, 9'h08E, 1'b1, 4'd9, 1'b0, 1'b0};
    tbl[19] = '{9'h001, 1'b0, 1'b0, 9'h171, 9'h08E, 1'b1, 4'd9, 1'b0, 1'b1};
    tbl[20] = '{9'h002, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[21] = '{9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 4'd0, 1'b0, 1'b0};

    // Reset with cell 4 held.
    res = 1'b0; p3 = 9'h010; clr3 = 1'b0; dis3 = 1'b0;
    p4 = '0; clr4 = 1'b0; dis4 = 1'b0;
    #12;
    check3("rst3", 9'h000, 9'h000, 1'b0, 4'd0, 1'b0, 1'b0);
    check4("rst4", 16'h0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #10 res = 1'b1;
    inv_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step3(9'h010, 1'b0, 1'b0);
      check3($sformatf("held%0d", i), 9'h000, 9'h000, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    step3(9'h000, 1'b0, 1'b0);
    step3(9'h010, 1'b0, 1'b0);
    check3("first", 9'h010, 9'h000, 1'b1, 4'd1, 1'b1, 1'b0);

    for (int i = 0; i < 22; i++) begin
      step3(tbl[i].p, tbl[i].c, tbl[i].d);
      check3($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].est, tbl[i].ecnt,
             tbl[i].eok, tbl[i].erej);
    end

    // 4x4 with alternating start player.
    step4(16'h0000, 1'b1);
    check4("d4_clr1", 16'h0, 16'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    step4(16'h0000, 1'b1);
    check4("d4_clr2", 16'h0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    step4(16'h0001, 1'b1);
    check4("d4_clrpress", 16'h0, 16'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    step4(16'h0000, 1'b1);
    check4("d4_clr4", 16'h0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    step4(16'h8000, 1'b0);
    check4("d4_m1", 16'h8000, 16'h0, 1'b1, 5'd1, 1'b1, 1'b0);
    step4(16'h8001, 1'b0);
    check4("d4_m2", 16'h8000, 16'h0001, 1'b0, 5'd2, 1'b1, 1'b0);

    // Random stream on the 3x3 instance.
    step3(9'h000, 1'b1, 1'b0);
    model_clear();
    prev = 9'h000;
    for (int it = 0; it < 800; it++) begin
      logic [8:0] p;
      logic       c, d;
      int         r, nr, last;
      logic       e_ok, e_rej;
      if (it == 400) begin
        // Asynchronous reset mid-game with buttons held.
        res = 1'b0;
        #3;
        chk("midrst_A", 32'(a3), 32'd0);
        chk("midrst_cnt", 32'(cnt3), 32'd0);
        res = 1'b1;
        model_clear();
        prev = 9'h1FF;
      end
      p = p3;
      r = int'($urandom_range(0, 99));
      if (r < 65) p = p ^ (9'(1) << $urandom_range(0, 8));
      else if (r < 75) p = p | (9'(1) << $urandom_range(0, 8)) | (9'(1) << $urandom_range(0, 8));
      else if (r < 85) p = 9'h000;
      c = ($urandom_range(0, 49) == 0);
      d = ($urandom_range(0, 11) == 0);

      nr = 0; last = 0; e_ok = 1'b0; e_rej = 1'b0;
      for (int k = 0; k < 9; k++) if (p[k] && !prev[k]) begin nr++; last = k; end
      if (c) begin
        model_clear();
      end else if (nr > 0) begin
        if (nr > 1 || d || moves == 9 || owner[last] != 0) e_rej = 1'b1;
        else begin
          owner[last] = turn + 1;
          turn  = 1 - turn;
          moves = moves + 1;
          e_ok  = 1'b1;
        end
      end
      prev = p;

      step3(p, c, d);
      check3($sformatf("rnd%0d", it), own_vec(1), own_vec(2), turn[0], 4'(moves), e_ok, e_rej);
    end

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
